// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU sequencer
//
// Purpose : op encodings, FSM state enumeration and settle-counter width
//           used by alu_sequencer, settle_counter and alu_sequencer_if.
// Ports   : none (package).
// Config  : ALU_SEQ_OVERFLOW_EN is consumed by the interface and top, not here.

package alu_seq_pkg;

  // Wide enough for SETTLE_CYCLES-1 over the legal range 1..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_LDN = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SETTLE,
    ST_LATCH,
    ST_DRIVE,
    ST_CMP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request, status and ALU strobe bundle for alu_sequencer
//
// Purpose : groups the sequencer's request/status handshake and ALU control lines.
// Signals : start, op[1:0], acc_sign, mem_sign, result_sign  (master -> slave)
//           alu_sub, alu_a_zero, alu_le, alu_oe_n, acc_we,
//           busy, done, skip, illegal [, overflow]           (slave -> master)
// Modports: master (requester / datapath side), slave (sequencer).
// Config  : ALU_SEQ_OVERFLOW_EN adds the overflow status line.

interface alu_sequencer_if;

  logic       start;
  logic [1:0] op;
  logic       acc_sign;
  logic       mem_sign;
  logic       result_sign;

  logic       alu_sub;
  logic       alu_a_zero;
  logic       alu_le;
  logic       alu_oe_n;
  logic       acc_we;
  logic       busy;
  logic       done;
  logic       skip;
  logic       illegal;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic       overflow;
`endif

  modport master (
    output start, op, acc_sign, mem_sign, result_sign,
    input  alu_sub, alu_a_zero, alu_le, alu_oe_n, acc_we,
    input  busy, done, skip, illegal
`ifdef ALU_SEQ_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  start, op, acc_sign, mem_sign, result_sign,
    output alu_sub, alu_a_zero, alu_le, alu_oe_n, acc_we,
    output busy, done, skip, illegal
`ifdef ALU_SEQ_OVERFLOW_EN
    , output overflow
`endif
  );

endinterface

// File: rtl/alu_sequencer_settle_counter.sv
// rtl/alu_sequencer_settle_counter.sv - down-counter timing the adder settle window
//
// Purpose : loadable down-counter with a zero flag; stops at zero.
// Ports   : clk, reset (async, active-high), load, load_value[CNT_W-1:0],
//           dec, zero.

module settle_counter
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - microsequencer driving a ripple-carry ALU for LDN/SUB/CMP
//
// Purpose : steps the ALU through setup, settle, latch and drive for LDN/SUB,
//           resolves CMP from the accumulator sign, flags illegal ops.
// Ports   : clk, reset (async, active-high), bus (alu_sequencer_if.slave).
// Params  : SETTLE_CYCLES (1..15) cycles of adder settling before latching.
// Config  : ALU_SEQ_OVERFLOW_EN enables the signed-overflow flag.
//
// All outputs are registered and change together with the state, so each
// output reflects the state the FSM is in during that cycle.

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e state;
  logic   alu_sub_q;
  logic   alu_a_zero_q;
  logic   alu_le_q;
  logic   alu_oe_n_q;
  logic   acc_we_q;
  logic   busy_q;
  logic   done_q;
  logic   skip_q;
  logic   illegal_q;
  logic   cnt_zero;

  // Loaded during SETUP so it reads SETTLE_CYCLES-1 in the first SETTLE cycle.
  settle_counter u_settle (
    .clk        (clk),
    .reset      (reset),
    .load       (state == ST_SETUP),
    .load_value (SETTLE_LOAD),
    .dec        (state == ST_SETTLE),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      alu_sub_q    <= 1'b0;
      alu_a_zero_q <= 1'b0;
      alu_le_q     <= 1'b0;
      alu_oe_n_q   <= 1'b1;
      acc_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      skip_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      // Single-cycle strobes fall back to idle unless the next state wants them.
      alu_le_q   <= 1'b0;
      alu_oe_n_q <= 1'b1;
      acc_we_q   <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            case (op_e'(bus.op))
              OP_LDN: begin
                state        <= ST_SETUP;
                alu_sub_q    <= 1'b1;
                alu_a_zero_q <= 1'b1;
              end
              OP_SUB: begin
                state        <= ST_SETUP;
                alu_sub_q    <= 1'b1;
                alu_a_zero_q <= 1'b0;
              end
              OP_CMP: begin
                state <= ST_CMP;
              end
              OP_ILL: begin
                state     <= ST_DONE;
                illegal_q <= 1'b1;
                done_q    <= 1'b1;
              end
            endcase
          end
        end
        ST_SETUP: begin
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            state    <= ST_LATCH;
            alu_le_q <= 1'b1;
          end
        end
        ST_LATCH: begin
          state      <= ST_DRIVE;
          alu_oe_n_q <= 1'b0;
          acc_we_q   <= 1'b1;
        end
        ST_DRIVE: begin
          state        <= ST_DONE;
          done_q       <= 1'b1;
          alu_sub_q    <= 1'b0;
          alu_a_zero_q <= 1'b0;
        end
        ST_CMP: begin
          state  <= ST_DONE;
          skip_q <= bus.acc_sign;
          done_q <= 1'b1;
        end
        ST_DONE: begin
          // start is deliberately not examined here: no queuing.
          state     <= ST_IDLE;
          busy_q    <= 1'b0;
          skip_q    <= 1'b0;
          illegal_q <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_OVERFLOW_EN
  logic overflow_q;
  logic a_sign;

  // LDN feeds constant zero into A, so its sign is 0 rather than the accumulator's.
  assign a_sign = alu_a_zero_q ? 1'b0 : bus.acc_sign;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (state == ST_DRIVE) begin
      overflow_q <= (a_sign != bus.mem_sign) && (bus.result_sign != a_sign);
    end else if (state == ST_DONE) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.overflow = overflow_q;
`else
  logic unused_signs;
  assign unused_signs = bus.mem_sign ^ bus.result_sign;
`endif

  assign bus.alu_sub    = alu_sub_q;
  assign bus.alu_a_zero = alu_a_zero_q;
  assign bus.alu_le     = alu_le_q;
  assign bus.alu_oe_n   = alu_oe_n_q;
  assign bus.acc_we     = acc_we_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.skip       = skip_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, number of clock cycles allowed for adder ripple-carry settling before latching; legal range 1..15.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 LDN (acc = 0 - mem), 01 SUB (acc = acc - mem), 10 CMP (skip if acc negative), 11 illegal.
REQ-006 acc_sign  input  1  accumulator bit 31.
REQ-007 mem_sign  input  1  memory operand bit 31.
REQ-008 result_sign  input  1  ALU RESULT bit 31.
REQ-009 alu_sub  output  1  drives ALU SUB.
REQ-010 alu_a_zero  output  1  selects constant zero onto ALU A input.
REQ-011 alu_le  output  1  drives ALU latch enable.
REQ-012 alu_oe_n  output  1  drives ALU output enable, active low.
REQ-013 acc_we  output  1  accumulator write strobe.
REQ-014 busy  output  1  high from the cycle after acceptance until the DONE cycle inclusive.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 skip  output  1  CMP result, valid while done=1.
REQ-017 illegal  output  1  op=11 flag, valid while done=1.
REQ-018 overflow  output  1  signed-overflow flag, valid while done=1 (present only when configured, REQ-031).

Function
REQ-019 States SHALL be IDLE, SETUP, SETTLE, LATCH, DRIVE, CMP, DONE.
REQ-020 IDLE with start=1 SHALL go to SETUP for op 00/01, to CMP for op 10, and to DONE with illegal=1 for op 11; op is captured on acceptance.
REQ-021 start outside IDLE SHALL be ignored, not queued.
REQ-022 SETUP: alu_sub=1, alu_a_zero=1 for LDN and 0 for SUB; both held stable through DRIVE; next state SETTLE with counter loaded to SETTLE_CYCLES-1.
REQ-023 SETTLE SHALL decrement once per cycle and exit to LATCH the cycle after the counter reads 0, giving exactly SETTLE_CYCLES cycles.
REQ-024 LATCH: alu_le=1 for exactly one cycle; next DRIVE.
REQ-025 DRIVE: alu_oe_n=0 and acc_we=1 for exactly one cycle; next DONE.
REQ-026 CMP: skip captured as acc_sign; no ALU output is driven; next DONE.
REQ-027 DONE: done=1 one cycle, skip/illegal/overflow held valid; next IDLE; a start in this cycle is ignored.
REQ-028 Latency start-to-done: LDN/SUB = SETTLE_CYCLES+4 cycles; CMP = 2; illegal = 1.
REQ-029 alu_oe_n SHALL be 1 and acc_we 0 in every state except DRIVE; alu_le 0 except LATCH.

Reset
REQ-030 reset SHALL immediately force IDLE, alu_oe_n=1 and all other outputs 0, abandoning any operation; no acc_we is issued for an aborted operation.

Configuration
REQ-031 Macro ALU_SEQ_OVERFLOW_EN: when defined, overflow port exists and is captured in DRIVE as (A_sign != mem_sign) && (result_sign != A_sign), with A_sign = 0 for LDN, acc_sign for SUB; when undefined, port and logic are absent.

Structure
REQ-032 Package alu_seq_pkg SHALL hold op encodings, state enumeration and SETTLE counter width constant.
REQ-033 Sub-module settle_counter (load, decrement, zero flag) SHALL implement the SETTLE timer.

Verification
REQ-034 SETTLE_CYCLES=4, op=01, start pulse -> alu_le high cycle 6, acc_we/alu_oe_n=0 cycle 7, done cycle 8 after start.
REQ-035 op=00 -> alu_a_zero=1 and alu_sub=1 from SETUP through DRIVE; with mem_sign=1, result_sign=1 -> overflow=1 (macro defined).
REQ-036 op=10, acc_sign=1 -> done 2 cycles after start with skip=1; acc_sign=0 -> skip=0; acc_we never asserted.
REQ-037 op=11 -> done next cycle, illegal=1, no ALU strobes.
REQ-038 reset asserted during SETTLE -> alu_oe_n=1, busy=0 without clock edge; no acc_we follows; new start accepted after release.
REQ-039 start held high continuously -> back-to-back operations separated by one IDLE cycle, start in DONE ignored.
